// File: rtl/debounced_led_counter.sv
// debounced_led_counter
// LED counter stepped by an internal tick enable (no derived clocks).
// A debounced pushbutton toggles run/pause, dir selects up/down, SATURATE
// selects wrap or hold at the ends, and load writes a value and restarts
// the tick period. Everything runs on the rising edge of clk.
//
// Handshake note: there is no valid/ready traffic here. load is a plain
// single-cycle strobe, qualified only by clk, and always wins over a step.
module debounced_led_counter #(
  parameter int WIDTH     = 4,
  parameter int DIV_COUNT = 50_000_000,
  parameter int DEBOUNCE  = 1_000_000,
  parameter bit SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic             running,
  output logic             tick
);

  localparam int DIV_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
  localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
  localparam logic [WIDTH-1:0] LED_MAX  = '1;
  localparam logic [WIDTH-1:0] LED_ONE  = WIDTH'(1);

  // Synchroniser stages
  logic             sync1_q;
  logic             sync2_q;

  // Debouncer state
  logic             btn_db_q,      btn_db_d;
  logic             btn_db_prev_q;
  logic [DB_W-1:0]  db_cnt_q,      db_cnt_d;

  // Run flag, divider and counter
  logic             running_q,     running_d;
  logic [DIV_W-1:0] div_cnt_q,     div_cnt_d;
  logic [WIDTH-1:0] led_q,         led_d;
  logic             tick_q,        tick_d;

  logic             btn_rise;
  logic             wrap;

  // Two-flop synchroniser bringing the raw button into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Debouncer: accept a new level only after DEBOUNCE consecutive differing cycles
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = db_cnt_q;
    if (sync2_q == btn_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      btn_db_d = sync2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_ONE;
    end
  end

  // Only a clean rising edge of the debounced level toggles run/pause
  assign btn_rise  = btn_db_q & ~btn_db_prev_q;
  assign running_d = running_q ^ btn_rise;

  // The step decision uses the pre-edge run flag, so a toggle and a wrap
  // landing on the same edge both take effect.
  assign wrap = running_q && (div_cnt_q == DIV_LAST);

  // Divider, tick and LED next-state; load beats step beats hold
  always_comb begin
    div_cnt_d = div_cnt_q;
    led_d     = led_q;
    tick_d    = 1'b0;
    if (load) begin
      led_d     = load_val;
      div_cnt_d = '0;
    end else if (wrap) begin
      div_cnt_d = '0;
      tick_d    = 1'b1;
      if (!dir) begin
        if (!(SATURATE && (led_q == LED_MAX))) begin
          led_d = led_q + LED_ONE;
        end
      end else begin
        if (!(SATURATE && (led_q == '0))) begin
          led_d = led_q - LED_ONE;
        end
      end
    end else if (running_q) begin
      div_cnt_d = div_cnt_q + DIV_ONE;
    end
  end

  // State registers for debouncer, run flag, divider and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      db_cnt_q      <= '0;
      running_q     <= 1'b1;
      div_cnt_q     <= '0;
      led_q         <= '0;
      tick_q        <= 1'b0;
    end else begin
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_q;
      db_cnt_q      <= db_cnt_d;
      running_q     <= running_d;
      div_cnt_q     <= div_cnt_d;
      led_q         <= led_d;
      tick_q        <= tick_d;
    end
  end

  assign led     = led_q;
  assign running = running_q;
  assign tick    = tick_q;

endmodule

// File: doc/debounced_led_counter.md
# debounced_led_counter

Parametrised LED counter that advances on an internally generated tick, with a debounced run/pause button, up/down direction, wrap or saturate mode and a synchronous load. It sits between the board pushbutton/switch inputs and the LED bank. It replaces a derived slow clock with a single-cycle tick enable, so the whole block runs in the `clk` domain.

## Interface
- `WIDTH`, default 4: counter and LED width in bits (≥1).
- `DIV_COUNT`, default 50_000_000: `clk` cycles per tick (≥2); 1 Hz at 50 MHz.
- `DEBOUNCE`, default 1_000_000: consecutive stable cycles required to accept a button level change (≥1).
- `SATURATE`, default 0: 0 = wrap at the ends, 1 = hold at the ends.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn`  in  1  raw pushbutton, active-high. Asynchronous to `clk` and may bounce.
- `dir`  in  1  0 = count up, 1 = count down. Sampled on tick edges.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  WIDTH  value written to `led` on `load`.
- `led`  out  WIDTH  counter value, registered.
- `running`  out  1  1 = counting enabled, registered.
- `tick`  out  1  one-cycle pulse marking each count step, registered.

## Operation
- **Reset values:** `led`=0, `running`=1, `tick`=0. The internal divider `div_cnt`=0, the synchroniser flops are 0, `btn_db`=0 and `db_cnt`=0.
- **Synchroniser:** two-flop synchroniser takes `btn` to `btn_s`.
- **Debouncer:**
  - If `btn_s`==`btn_db`, then `db_cnt`←0.
  - Otherwise `db_cnt` increments. On the cycle it equals `DEBOUNCE`-1, `btn_db`←`btn_s` and `db_cnt`←0.
  - The counter is sized as clog2(`DEBOUNCE`+1) bits.
- **Run toggle:** a rising edge of `btn_db` (registered previous value 0, current value 1) toggles `running` on the following edge. Falling edges of `btn_db` have no effect.
- **Divider (when `running`=1):** `div_cnt` counts 0..`DIV_COUNT`-1 and wraps to 0. The wrap edge is the step edge.
- **Divider (when `running`=0):** `div_cnt` holds its value, so a resume continues the partial period.
- **Step edge:**
  - `tick`←1 for one cycle; `tick`←0 on every other edge.
  - With `dir`=0: `led`←`led`+1.
  - With `dir`=1: `led`←`led`-1.
  - Arithmetic is modulo 2^`WIDTH`.
- **Saturate mode (`SATURATE`=1):**
  - Counting up at all-ones: `led` holds.
  - Counting down at 0: `led` holds.
  - `tick` still pulses in both cases.
- **Load:** when `load`=1, `led`←`load_val` and `div_cnt`←0, and `tick`←0 that edge. This happens regardless of `running`.
- **Priority:** `rst` > `load` > step > hold.
- **Simultaneous toggle and wrap:** the step uses the pre-edge `running` value. A toggle and a wrap on the same edge both take effect.
- **Reset mid-operation:** any in-progress debounce, partial period or pending toggle is discarded.

## Timing
- Number edges from 1 at the first edge with `rst`=0.
- **Free-running step:** with `running`=1 and no load, `div_cnt` wraps at edge k·`DIV_COUNT`. `led` changes and `tick`=1 in the cycle after that edge.
- **Load latency:** `led` shows `load_val` the cycle after the load edge. The next step occurs `DIV_COUNT` edges after the load edge.
- **Button latency:** let edge *a* be the first edge that samples `btn` high.
  - `btn_s`=1 after edge *a*+1.
  - `btn_db`=1 after edge *a*+1+`DEBOUNCE`.
  - `running` toggles at edge *a*+`DEBOUNCE`+2.
- **Glitch rejection:** a pulse on `btn_s` shorter than `DEBOUNCE` cycles never changes `btn_db`.
- **Throughput:** at most one step per `DIV_COUNT` cycles. `tick` is never high on two consecutive cycles.

## Test plan
All scenarios use `WIDTH`=4, `DIV_COUNT`=4, `DEBOUNCE`=3 unless stated.
1. **Free run:** release `rst`, `dir`=0, `btn`=0 → `led`=1 after edge 4 and `tick` high only in cycles following edges 4, 8, 12, …; after edge 64, `led` wraps to 0.
2. **Saturate down:** `SATURATE`=1, `dir`=1 from reset → `led` stays 0 while `tick` still pulses every 4 cycles; `load` 4'hE, then `dir`=0 → `led`=F after the next step and stays F.
3. **Debounce:** `btn` high 2 cycles → `running` stays 1; `btn` held high 10 cycles from edge *a* → `running`=0 at edge *a*+5, with `div_cnt` and `led` frozen; a second clean press resumes the partial period.
4. **Load collision:** `load`=1 with `load_val`=4'hA on a wrap edge → `led`=A, `tick`=0, next `tick` 4 edges later, `led`=B.
5. **Load while paused:** pause, `load`=1 with `load_val`=4'h5 → `led`=5, with no ticks until resume.
6. **Mid-operation reset:** assert `rst` while `div_cnt`=2, `led`=7 and a debounce is in progress → after one edge `led`=0, `running`=1, `tick`=0; next step at edge 4 after release.
